// File: rtl/vend_pkg.sv
// Shared state codes and width helpers for the vending engine.
package vend_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_ACCUM    = 2'd1;
  localparam state_t ST_DISPENSE = 2'd2;
  localparam state_t ST_CHANGE   = 2'd3;

  // Index width never collapses to zero, so a single-product build still has a port.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned tot_w(input int unsigned w);
    return w + 1;
  endfunction

endpackage

// File: rtl/vend_price_table.sv
// Per-product price registers: one synchronous write port, one asynchronous read port.
module vend_price_table
  import vend_pkg::*;
#(
  parameter  int unsigned WIDTH         = 8,
  parameter  int unsigned N_ITEMS       = 4,
  parameter  int unsigned DEFAULT_PRICE = 100,
  localparam int unsigned IDX_W         = idx_w(N_ITEMS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] price_q [N_ITEMS];
  logic [WIDTH-1:0] price_d [N_ITEMS];
  logic [31:0]      wr_idx_ext;
  logic [31:0]      rd_idx_ext;

  always_comb begin
    wr_idx_ext = {{(32-IDX_W){1'b0}}, wr_idx};
    rd_idx_ext = {{(32-IDX_W){1'b0}}, rd_idx};
    price_d    = price_q;
    if (we && (wr_idx_ext < N_ITEMS)) begin
      price_d[wr_idx] = wr_data;
    end
  end

  // Out-of-range selections see the highest possible price so they can never dispense for free.
  always_comb begin
    rd_data = '1;
    if (rd_idx_ext < N_ITEMS) begin
      rd_data = price_q[rd_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_ITEMS; i++) begin
        price_q[i] <= WIDTH'(DEFAULT_PRICE);
      end
    end else begin
      price_q <= price_d;
    end
  end

endmodule

// File: rtl/vend_engine.sv
// Vending controller: accumulates credit, validates selections, dispenses and pays change in bounded beats.
module vend_engine
  import vend_pkg::*;
#(
  parameter  int unsigned WIDTH         = 8,
  parameter  int unsigned N_ITEMS       = 4,
  parameter  int unsigned CHG_UNIT      = 25,
  parameter  int unsigned DEFAULT_PRICE = 100,
  localparam int unsigned IDX_W         = idx_w(N_ITEMS),
  localparam int unsigned TOT_W         = tot_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coin_valid,
  input  logic [WIDTH-1:0] coin_val,
  output logic             coin_ready,
  input  logic             sel_valid,
  input  logic [IDX_W-1:0] sel_idx,
  output logic             sel_err,
  input  logic             cancel,
  input  logic             price_we,
  input  logic [IDX_W-1:0] price_idx,
  input  logic [WIDTH-1:0] price_data,
  output logic             disp_valid,
  output logic [IDX_W-1:0] disp_idx,
  input  logic             disp_ready,
  output logic             chg_valid,
  output logic [WIDTH-1:0] chg_amt,
  input  logic             chg_ready,
  output logic [TOT_W-1:0] tot,
  output logic             busy
);

  localparam int unsigned      EXT_W   = TOT_W + 1;
  localparam logic [EXT_W-1:0] TOT_MAX = {1'b0, {TOT_W{1'b1}}};
  localparam logic [WIDTH-1:0] CHG_W   = WIDTH'(CHG_UNIT);

  state_t           state_q, state_d;
  logic [TOT_W-1:0] tot_q, tot_d;
  logic [IDX_W-1:0] disp_idx_q, disp_idx_d;
  logic             sel_err_q, sel_err_d;

  logic [WIDTH-1:0] sel_price;
  logic             coin_acc;
  logic             sel_ok;
  logic [EXT_W-1:0] tot_ext, coin_ext, sum_ext, net_ext;
  logic [WIDTH-1:0] chg_beat;

  function automatic logic [TOT_W-1:0] sat(input logic [EXT_W-1:0] x);
    return (x > TOT_MAX) ? '1 : x[TOT_W-1:0];
  endfunction

  vend_price_table #(
    .WIDTH         (WIDTH),
    .N_ITEMS       (N_ITEMS),
    .DEFAULT_PRICE (DEFAULT_PRICE)
  ) u_prices (
    .clk     (clk),
    .rst     (rst),
    .we      (price_we),
    .wr_idx  (price_idx),
    .wr_data (price_data),
    .rd_idx  (sel_idx),
    .rd_data (sel_price)
  );

  assign coin_ready = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
  assign busy       = (state_q == ST_DISPENSE) || (state_q == ST_CHANGE);
  assign disp_valid = (state_q == ST_DISPENSE);
  assign chg_valid  = (state_q == ST_CHANGE);
  assign chg_amt    = chg_valid ? chg_beat : '0;
  assign disp_idx   = disp_idx_q;
  assign sel_err    = sel_err_q;
  assign tot        = tot_q;

  always_comb begin
    coin_acc = coin_valid && coin_ready;
    tot_ext  = {1'b0, tot_q};
    coin_ext = coin_acc ? {{(EXT_W-WIDTH){1'b0}}, coin_val} : '0;
    sum_ext  = tot_ext + coin_ext;
    // Selection is judged on the registered credit, before this cycle's coin lands.
    sel_ok   = tot_ext >= {{(EXT_W-WIDTH){1'b0}}, sel_price};
    net_ext  = sum_ext - {{(EXT_W-WIDTH){1'b0}}, sel_price};
    chg_beat = (tot_q < {1'b0, CHG_W}) ? tot_q[WIDTH-1:0] : CHG_W;

    state_d    = state_q;
    tot_d      = tot_q;
    disp_idx_d = disp_idx_q;
    sel_err_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (coin_acc) begin
          tot_d   = sat(sum_ext);
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (cancel) begin
          tot_d   = sat(sum_ext);
          state_d = (sum_ext != '0) ? ST_CHANGE : ST_IDLE;
        end else if (sel_valid && sel_ok) begin
          tot_d      = sat(net_ext);
          disp_idx_d = sel_idx;
          state_d    = ST_DISPENSE;
        end else begin
          tot_d     = sat(sum_ext);
          sel_err_d = sel_valid;
        end
      end
      ST_DISPENSE: begin
        if (disp_ready) begin
          state_d = (tot_q != '0) ? ST_CHANGE : ST_IDLE;
        end
      end
      ST_CHANGE: begin
        if (chg_ready) begin
          tot_d = tot_q - {1'b0, chg_beat};
          if (tot_d == '0) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tot_q      <= '0;
      disp_idx_q <= '0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tot_q      <= tot_d;
      disp_idx_q <= disp_idx_d;
      sel_err_q  <= sel_err_d;
    end
  end

endmodule

// File: doc/vend_engine.md
VEND_ENGINE -- requirements
Module: vend_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, setting the width of coin values and prices.
REQ-002 SHALL have parameter N_ITEMS, default 4, setting the number of products; IDX_W = clog2(N_ITEMS).
REQ-003 SHALL have parameter CHG_UNIT, default 25, setting the largest change amount returned per handshake beat.
REQ-004 SHALL have parameter DEFAULT_PRICE, default 100, setting the reset value of every price entry.
REQ-005 SHALL define TOT_W = WIDTH+1 as the width of the running total.
REQ-006 SHALL provide these ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- coin_valid  in  1  coin present.
- coin_val  in  WIDTH  value of the inserted coin.
- coin_ready  out  1  coin can be accepted.
- sel_valid  in  1  product selection request.
- sel_idx  in  IDX_W  selected product index.
- sel_err  out  1  one-cycle pulse: selection rejected.
- cancel  in  1  return all credit.
- price_we  in  1  price table write enable.
- price_idx  in  IDX_W  price table write index.
- price_data  in  WIDTH  new price.
- disp_valid  out  1  dispense request.
- disp_idx  out  IDX_W  product to dispense.
- disp_ready  in  1  dispenser accepts the request.
- chg_valid  out  1  change beat is available.
- chg_amt  out  WIDTH  amount of this change beat.
- chg_ready  in  1  change mechanism accepts the beat.
- tot  out  TOT_W  current credit.
- busy  out  1  high in DISPENSE or CHANGE.

Function
REQ-007 SHALL implement a state machine with states IDLE, ACCUM, DISPENSE and CHANGE.
REQ-008 SHALL assert coin_ready only in IDLE and ACCUM; a coin is accepted when coin_valid and coin_ready are both high.
REQ-009 SHALL, in IDLE or ACCUM, add each accepted coin to tot, saturating at 2^TOT_W-1; IDLE moves to ACCUM on the first accepted coin.
REQ-010 SHALL, in ACCUM, compare a selection (sel_valid) against the registered tot before the same-cycle coin is added.
- If tot >= price[sel_idx]: next tot = tot + coin - price, latch disp_idx, go to DISPENSE.
- Otherwise: pulse sel_err for one cycle and leave tot unchanged except for the same-cycle coin.
REQ-011 SHALL ignore sel_valid in IDLE and SHALL NOT pulse sel_err there.
REQ-012 SHALL give cancel priority over sel_valid in ACCUM.
- Cancel with tot + coin > 0 goes to CHANGE.
- Cancel with tot + coin = 0 goes to IDLE.
REQ-013 SHALL, in DISPENSE, hold disp_valid high and disp_idx stable until disp_ready; it then goes to CHANGE if tot > 0, else to IDLE.
REQ-014 SHALL, in CHANGE, drive chg_valid high with chg_amt = min(CHG_UNIT, tot).
- Each chg_valid and chg_ready handshake subtracts chg_amt from tot.
- The block goes to IDLE on the beat that makes tot zero.
REQ-015 SHALL hold chg_amt and chg_valid stable while chg_ready is low.
REQ-016 SHALL ignore coin_valid, sel_valid and cancel in DISPENSE and CHANGE.
REQ-017 SHALL accept price writes in any state.
- The new price takes effect on the next cycle.
- A same-cycle selection of the written index uses the old price.
REQ-018 SHALL compute all total arithmetic at TOT_W+1 bits before saturation or clamping, so no wrap-around occurs.

Reset
REQ-019 SHALL, while rst is high, immediately force the following values regardless of clk:
- state = IDLE and tot = 0.
- disp_valid, chg_valid and sel_err = 0.
- chg_amt and disp_idx = 0.
- coin_ready = 1 and busy = 0.
REQ-020 SHALL, on reset, return every price entry to DEFAULT_PRICE and discard any in-progress credit, dispense or change.

Structure
REQ-021 SHALL take its state enum and width helper constants from the shared package vend_pkg.
REQ-022 SHALL place the price table in the sub-module vend_price_table, which has one write port and one asynchronous read port.

Verification
Parameters for all scenarios: WIDTH=8, N_ITEMS=4, CHG_UNIT=25, all prices 100.
REQ-023 SHALL cover exact payment: coins 25, 25, 50, then sel_idx=0 -> disp_valid with disp_idx=0, tot=0, back to IDLE with no chg_valid.
REQ-024 SHALL cover change return: coins 100 and 50, then sel_idx=2 -> dispense, then change beats of 25 and 25, then IDLE.
REQ-025 SHALL cover short credit: coin 50, then select -> sel_err for one cycle and tot stays 50; then cancel -> change 25, 25.
REQ-026 SHALL cover simultaneous events: tot=100 with coin 30 and select in the same cycle -> dispense and tot=30.
- With chg_ready held low for 3 cycles, chg_amt stays 25.
- The change beats are then 25 and 5.
REQ-027 SHALL cover saturation: coins 255, 255, 255 -> tot=511 and no wrap-around.
REQ-028 SHALL cover reset mid-operation: assert rst during CHANGE -> all outputs reach their reset values without a clk edge, and the price table reads 100.
